// File: rtl/cpu_mem_port.sv
// cpu_mem_port: splits one CPU byte access into one or two 32-bit memory word transactions.
// Define CPU_MEM_PORT_MISALIGN_EN to split spanning accesses; otherwise they are rejected with cpu_err.
module cpu_mem_port #(
    parameter int TIMEOUT = 255,
    parameter int AW      = 26
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    input  logic [1:0]    cpu_wlen,
    input  logic [31:0]   cpu_wdata,
    output logic          cpu_busy,
    output logic          cpu_done,
    output logic          cpu_err,
    output logic [31:0]   cpu_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-3:0] mem_addr,
    output logic [3:0]    mem_be,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ack,
    input  logic [31:0]   mem_rdata
);
    localparam int CW = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t        r_state, w_next;
    logic [AW-1:0] r_addr;
    logic [1:0]    r_wlen;
    logic [31:0]   r_wdata, r_rdata;
    logic          r_err, r_gap;
    logic [CW-1:0] r_cnt;
`ifdef CPU_MEM_PORT_MISALIGN_EN
    logic          r_span;
    logic [31:0]   r_lo;
    logic [63:0]   w_rd_wide;
`endif
    logic [1:0]    w_off;
    logic [3:0]    w_mask;
    logic [7:0]    w_be_wide;
    logic [63:0]   w_wd_wide;
    logic [2:0]    w_in_size;
    logic          w_in_span, w_hi, w_ack, w_timeout;

    always_comb begin
        w_off     = r_addr[1:0];
        w_mask    = r_wlen == 2'd1 ? 4'h1 : r_wlen == 2'd2 ? 4'h3 : 4'hF;
        w_be_wide = {4'h0, w_mask} << w_off;
        w_wd_wide = {32'h0, r_wdata} << {w_off, 3'b000};
`ifdef CPU_MEM_PORT_MISALIGN_EN
        w_rd_wide = {mem_rdata, r_lo} >> {w_off, 3'b000};
`endif
        w_in_size = cpu_wlen == 2'd1 ? 3'd1 : cpu_wlen == 2'd2 ? 3'd2 : 3'd4;
        w_in_span = ({1'b0, cpu_addr[1:0]} + w_in_size) > 3'd4;
        w_hi      = r_state == HI;
        // HI idles for one cycle after the LO ack to give the required bus gap
        mem_req   = r_state == LO || (w_hi && !r_gap);
        mem_we    = mem_req && r_wlen != 2'd0;
        mem_addr  = mem_req ? r_addr[AW-1:2] + (AW-2)'(w_hi) : '0;
        mem_be    = !mem_req ? 4'h0 : r_wlen == 2'd0 ? 4'hF : w_hi ? w_be_wide[7:4] : w_be_wide[3:0];
        mem_wdata = !mem_we ? 32'h0 : w_hi ? w_wd_wide[63:32] : w_wd_wide[31:0];
        w_ack     = mem_req && mem_ack;
        w_timeout = TIMEOUT != 0 && mem_req && !mem_ack && r_cnt == CW'(TIMEOUT - 1);
        cpu_busy  = r_state == LO || w_hi;
        cpu_done  = r_state == DONE;
        cpu_err   = cpu_done && r_err;
        cpu_rdata = r_rdata;
        w_next    = r_state;
        case (r_state)
            IDLE:
`ifdef CPU_MEM_PORT_MISALIGN_EN
                w_next = cpu_req ? LO : IDLE;
            LO:  w_next = w_ack ? (r_span ? HI : DONE) : w_timeout ? DONE : LO;
            HI:  w_next = (w_ack || w_timeout) ? DONE : HI;
`else
                w_next = !cpu_req ? IDLE : w_in_span ? DONE : LO;
            LO:  w_next = (w_ack || w_timeout) ? DONE : LO;
`endif
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_wlen  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_gap   <= 1'b0;
            r_cnt   <= '0;
`ifdef CPU_MEM_PORT_MISALIGN_EN
            r_span  <= 1'b0;
            r_lo    <= '0;
`endif
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state) ? '0 : (mem_req && !mem_ack) ? r_cnt + 1'b1 : r_cnt;
            r_gap   <= r_state == LO && w_next == HI;
            if (r_state == IDLE && cpu_req) begin
                r_addr  <= cpu_addr;
                r_wlen  <= cpu_wlen;
                r_wdata <= cpu_wdata;
`ifdef CPU_MEM_PORT_MISALIGN_EN
                r_span  <= w_in_span;
                r_err   <= 1'b0;
`else
                r_err   <= w_in_span;
                if (w_in_span)
                    r_rdata <= '0;
`endif
            end
            if (w_timeout)
                r_err <= 1'b1;
            if (w_ack && r_wlen == 2'd0) begin
`ifdef CPU_MEM_PORT_MISALIGN_EN
                if (w_hi)
                    r_rdata <= w_rd_wide[31:0];
                else if (r_span)
                    r_lo <= mem_rdata;
                else
                    r_rdata <= mem_rdata;
`else
                r_rdata <= mem_rdata;
`endif
            end
        end
    end
endmodule

// File: tb/tb_cpu_mem_port.sv
// tb_cpu_mem_port: directed self-checking bench for cpu_mem_port with TIMEOUT=4.
module tb_cpu_mem_port;
    logic        clk = 1'b0;
    logic        clr_n, cpu_req;
    logic [25:0] cpu_addr;
    logic [1:0]  cpu_wlen;
    logic [31:0] cpu_wdata;
    logic        cpu_busy, cpu_done, cpu_err;
    logic [31:0] cpu_rdata;
    logic        mem_req, mem_we;
    logic [23:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    int checks = 0;
    int errors = 0;
    logic ack_en = 1'b0;
    int n_tx = 0;
    int req_cycles = 0;
    logic [23:0] lg_addr[8];
    logic [3:0]  lg_be[8];
    logic [31:0] lg_wd[8];
    logic        lg_we[8];

    cpu_mem_port #(.TIMEOUT(4), .AW(26)) dut (
        .clk(clk), .clr_n(clr_n), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
        .cpu_wlen(cpu_wlen), .cpu_wdata(cpu_wdata), .cpu_busy(cpu_busy),
        .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [23:0] a);
        case (a)
            24'h000040: return 32'hDEADBEEF;
            24'h000001: return 32'h44332211;
            24'h000002: return 32'h88776655;
            default:    return 32'h0;
        endcase
    endfunction

    // memory responder: answers mid-cycle and logs every acked transaction
    always @(negedge clk) begin
        if (mem_req) req_cycles = req_cycles + 1;
        mem_ack = ack_en && mem_req;
        if (mem_ack) begin
            lg_addr[n_tx & 7] = mem_addr;
            lg_be[n_tx & 7]   = mem_be;
            lg_wd[n_tx & 7]   = mem_wdata;
            lg_we[n_tx & 7]   = mem_we;
            n_tx = n_tx + 1;
        end
        mem_rdata = mem_ack ? mem_word(mem_addr) : 32'h0;
    end

    task automatic do_req(input logic [25:0] a, input logic [1:0] l, input logic [31:0] d,
                          output int lat, output logic busy1, output logic [31:0] rd, output logic err);
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_addr = a; cpu_wlen = l; cpu_wdata = d;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        busy1 = cpu_busy;
        lat = 1;
        while (!cpu_done && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = cpu_rdata;
        err = cpu_err;
    endtask

    task automatic test_reset;
        clr_n = 1'b0; cpu_req = 1'b0; cpu_addr = '0; cpu_wlen = '0; cpu_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({cpu_busy, cpu_done, cpu_err, mem_req, mem_we} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b exp 00000", {cpu_busy, cpu_done, cpu_err, mem_req, mem_we}); end
        checks++; if ({cpu_rdata, mem_be, mem_addr, mem_wdata} !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", {cpu_rdata, mem_be, mem_addr, mem_wdata}); end
        clr_n = 1'b1;
        @(posedge clk); #1;
        checks++; if ({cpu_busy, cpu_done, mem_req} !== 3'b0) begin errors++; $display("FAIL reset_idle got %b exp 000", {cpu_busy, cpu_done, mem_req}); end
    endtask

    task automatic test_read_aligned;
        int lat, n0; logic b; logic [31:0] rd; logic e;
        ack_en = 1'b1; n0 = n_tx;
        do_req(26'h0000100, 2'b00, 32'h0, lat, b, rd, e);
        checks++; if (lat !== 2) begin errors++; $display("FAIL rd_lat got %0d exp 2", lat); end
        checks++; if (b !== 1'b1) begin errors++; $display("FAIL rd_busy got %b exp 1", b); end
        checks++; if (n_tx - n0 !== 1) begin errors++; $display("FAIL rd_ntx got %0d exp 1", n_tx - n0); end
        checks++; if ({lg_addr[n0 & 7], lg_be[n0 & 7], lg_we[n0 & 7]} !== {24'h000040, 4'hF, 1'b0}) begin errors++; $display("FAIL rd_bus got %h/%h/%b exp 000040/f/0", lg_addr[n0 & 7], lg_be[n0 & 7], lg_we[n0 & 7]); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h exp deadbeef", rd); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL rd_err got %b exp 0", e); end
    endtask

    task automatic test_write8;
        int lat, n0; logic b; logic [31:0] rd; logic e;
        ack_en = 1'b1; n0 = n_tx;
        do_req(26'h0000003, 2'b01, 32'h000000A5, lat, b, rd, e);
        checks++; if (n_tx - n0 !== 1 || lat !== 2) begin errors++; $display("FAIL w8_ntx got %0d/%0d exp 1/2", n_tx - n0, lat); end
        checks++; if ({lg_be[n0 & 7], lg_we[n0 & 7], lg_addr[n0 & 7]} !== {4'b1000, 1'b1, 24'h0}) begin errors++; $display("FAIL w8_bus got %b/%b/%h exp 1000/1/000000", lg_be[n0 & 7], lg_we[n0 & 7], lg_addr[n0 & 7]); end
        checks++; if (lg_wd[n0 & 7] !== 32'hA5000000) begin errors++; $display("FAIL w8_wdata got %h exp a5000000", lg_wd[n0 & 7]); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL w8_err got %b exp 0", e); end
    endtask

    task automatic test_write16_off2;
        int lat, n0; logic b; logic [31:0] rd; logic e;
        ack_en = 1'b1; n0 = n_tx;
        do_req(26'h000000A, 2'b10, 32'h0000BEEF, lat, b, rd, e);
        checks++; if (n_tx - n0 !== 1 || e !== 1'b0) begin errors++; $display("FAIL w16_ntx got %0d/%b exp 1/0", n_tx - n0, e); end
        checks++; if ({lg_addr[n0 & 7], lg_be[n0 & 7], lg_wd[n0 & 7]} !== {24'h000002, 4'hC, 32'hBEEF0000}) begin errors++; $display("FAIL w16_bus got %h/%h/%h exp 000002/c/beef0000", lg_addr[n0 & 7], lg_be[n0 & 7], lg_wd[n0 & 7]); end
    endtask

    task automatic test_span_read;
        int lat, n0, r0; logic b; logic [31:0] rd; logic e;
        ack_en = 1'b1; n0 = n_tx; r0 = req_cycles;
        do_req(26'h0000006, 2'b00, 32'h0, lat, b, rd, e);
`ifdef CPU_MEM_PORT_MISALIGN_EN
        checks++; if (n_tx - n0 !== 2 || lat !== 4 || req_cycles - r0 !== 2) begin errors++; $display("FAIL span_rd_shape got %0d/%0d/%0d exp 2/4/2", n_tx - n0, lat, req_cycles - r0); end
        checks++; if ({lg_addr[n0 & 7], lg_addr[(n0 + 1) & 7]} !== {24'h1, 24'h2}) begin errors++; $display("FAIL span_rd_addr got %h/%h exp 000001/000002", lg_addr[n0 & 7], lg_addr[(n0 + 1) & 7]); end
        checks++; if (rd !== 32'h66554433 || e !== 1'b0) begin errors++; $display("FAIL span_rd_data got %h/%b exp 66554433/0", rd, e); end
`else
        checks++; if (req_cycles - r0 !== 0 || lat !== 1) begin errors++; $display("FAIL span_rd_shape got %0d/%0d exp 0/1", req_cycles - r0, lat); end
        checks++; if (rd !== 32'h0 || e !== 1'b1) begin errors++; $display("FAIL span_rd_data got %h/%b exp 00000000/1", rd, e); end
`endif
    endtask

    task automatic test_wrap_write;
        int lat, n0, r0; logic b; logic [31:0] rd; logic e;
        ack_en = 1'b1; n0 = n_tx; r0 = req_cycles;
        do_req(26'h3FFFFFD, 2'b11, 32'hCAFEF00D, lat, b, rd, e);
`ifdef CPU_MEM_PORT_MISALIGN_EN
        checks++; if (n_tx - n0 !== 2 || e !== 1'b0) begin errors++; $display("FAIL wrap_ntx got %0d/%b exp 2/0", n_tx - n0, e); end
        checks++; if ({lg_addr[n0 & 7], lg_be[n0 & 7], lg_wd[n0 & 7]} !== {24'hFFFFFF, 4'hE, 32'hFEF00D00}) begin errors++; $display("FAIL wrap_lo got %h/%h/%h exp ffffff/e/fef00d00", lg_addr[n0 & 7], lg_be[n0 & 7], lg_wd[n0 & 7]); end
        checks++; if ({lg_addr[(n0 + 1) & 7], lg_be[(n0 + 1) & 7], lg_wd[(n0 + 1) & 7]} !== {24'h0, 4'h1, 32'h000000CA}) begin errors++; $display("FAIL wrap_hi got %h/%h/%h exp 000000/1/000000ca", lg_addr[(n0 + 1) & 7], lg_be[(n0 + 1) & 7], lg_wd[(n0 + 1) & 7]); end
`else
        checks++; if (req_cycles - r0 !== 0 || e !== 1'b1 || lat !== 1) begin errors++; $display("FAIL wrap_reject got %0d/%b/%0d exp 0/1/1", req_cycles - r0, e, lat); end
`endif
    endtask

    task automatic test_timeout;
        int lat, r0; logic b; logic [31:0] rd; logic e;
        ack_en = 1'b1;
        do_req(26'h0000100, 2'b00, 32'h0, lat, b, rd, e);
        ack_en = 1'b0; r0 = req_cycles;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_addr = 26'h0000200; cpu_wlen = 2'b00;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_addr = 26'h0000300;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        lat = 3;
        while (!cpu_done && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (lat !== 5 || req_cycles - r0 !== 4) begin errors++; $display("FAIL to_len got %0d/%0d exp 5/4", lat, req_cycles - r0); end
        checks++; if (cpu_err !== 1'b1 || cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL to_err got %b/%h exp 1/deadbeef", cpu_err, cpu_rdata); end
        repeat (4) @(posedge clk);
        #1;
        checks++; if (req_cycles - r0 !== 4 || cpu_busy !== 1'b0) begin errors++; $display("FAIL to_ignored got %0d/%b exp 4/0", req_cycles - r0, cpu_busy); end
    endtask

    task automatic test_reset_mid;
        int lat; logic b; logic [31:0] rd; logic e;
        ack_en = 1'b1;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_wlen = 2'b00;
`ifdef CPU_MEM_PORT_MISALIGN_EN
        cpu_addr = 26'h0000006;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(posedge clk); #1;
        ack_en = 1'b0;
        @(posedge clk); #1;
`else
        cpu_addr = 26'h0000100; ack_en = 1'b0;
        @(posedge clk); #1;
        cpu_req = 1'b0;
`endif
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rstmid_pre got %b exp 1", mem_req); end
        clr_n = 1'b0;
        #1;
        checks++; if ({mem_req, cpu_busy, cpu_done} !== 3'b0) begin errors++; $display("FAIL rstmid_drop got %b exp 000", {mem_req, cpu_busy, cpu_done}); end
        repeat (2) @(posedge clk);
        #1;
        clr_n = 1'b1; ack_en = 1'b1;
        do_req(26'h0000100, 2'b00, 32'h0, lat, b, rd, e);
        checks++; if (lat !== 2 || rd !== 32'hDEADBEEF || e !== 1'b0) begin errors++; $display("FAIL rstmid_after got %0d/%h/%b exp 2/deadbeef/0", lat, rd, e); end
    endtask

    initial begin
        test_reset;
        test_read_aligned;
        test_write8;
        test_write16_off2;
        test_span_read;
        test_wrap_write;
        test_timeout;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
